// File: rtl/fib_byte_streamer_if.sv
// Control and byte-stream bundle between the tile wrapper and fib_byte_streamer.
// The master side issues start/clear and accepts bytes; the slave side is the streamer.
interface fib_byte_streamer_if;
  logic       start;
  logic       clear;
  logic       out_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic       busy;
  logic       overflow;
  logic [7:0] term_idx;

  modport master (
    output start, clear, out_ready,
    input  out_valid, out_data, out_last, busy, overflow, term_idx
  );

  modport slave (
    input  start, clear, out_ready,
    output out_valid, out_data, out_last, busy, overflow, term_idx
  );
endinterface

// File: rtl/fib_byte_streamer.sv
// Fibonacci term generator that streams each term LSB-first as a byte frame.
// Define FIB_BYTE_STREAMER_CHECKSUM_EN to append an XOR checksum byte to every frame.
module fib_byte_streamer #(
  parameter int WIDTH = 32
) (
  input logic                clk,
  input logic                rst,
  fib_byte_streamer_if.slave bus
);
  localparam int BYTES = WIDTH / 8;
`ifdef FIB_BYTE_STREAMER_CHECKSUM_EN
  localparam int FRAME_BYTES = BYTES + 1;
`else
  localparam int FRAME_BYTES = BYTES;
`endif
  localparam int CW = $clog2(FRAME_BYTES) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_BYTES - 1);

  typedef enum logic [1:0] {IDLE, SEND, ADV} state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    bcnt;
  logic [7:0]       term_idx;
  logic             overflow;
  logic             fire;
  logic             last;
  logic [WIDTH:0]   sum;
`ifdef FIB_BYTE_STREAMER_CHECKSUM_EN
  logic [7:0]       csum;
`endif

  // Carry out of the (WIDTH+1)-bit sum is what marks a wrapped term.
  assign sum  = {1'b0, a} + {1'b0, b};
  assign last = (bcnt == LAST_CNT);

  assign bus.busy     = (state != IDLE);
  assign bus.term_idx = term_idx;
  assign bus.overflow = overflow;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next    = state;
    bus.out_valid = 1'b0;
    bus.out_data  = 8'h00;
    bus.out_last  = 1'b0;
    fire          = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) state_next = SEND;
      end
      SEND: begin
        bus.out_valid = 1'b1;
        bus.out_last  = last;
        bus.out_data  = shreg[7:0];
`ifdef FIB_BYTE_STREAMER_CHECKSUM_EN
        if (last) bus.out_data = csum;
`endif
        fire = bus.out_ready;
        if (fire && last) state_next = ADV;
      end
      ADV: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (bus.clear) state_next = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a        <= '0;
      b        <= WIDTH'(1);
      shreg    <= '0;
      bcnt     <= '0;
      term_idx <= 8'd0;
      overflow <= 1'b0;
    end else if (bus.clear) begin
      a        <= '0;
      b        <= WIDTH'(1);
      shreg    <= '0;
      bcnt     <= '0;
      term_idx <= 8'd0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            shreg <= a;
            bcnt  <= '0;
          end
        end
        SEND: begin
          if (fire && !last) begin
            shreg <= shreg >> 8;
            bcnt  <= bcnt + CW'(1);
          end
        end
        ADV: begin
          a        <= b;
          b        <= sum[WIDTH-1:0];
          term_idx <= term_idx + 8'd1;
          if (sum[WIDTH]) overflow <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef FIB_BYTE_STREAMER_CHECKSUM_EN
  // Running XOR of the term bytes as they are accepted; complete when the checksum slot is reached.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum <= 8'h00;
    end else if (bus.clear) begin
      csum <= 8'h00;
    end else if (state == IDLE && bus.start) begin
      csum <= 8'h00;
    end else if (state == SEND && fire && !last) begin
      csum <= csum ^ shreg[7:0];
    end
  end
`endif
endmodule

// File: tb/tb_fib_byte_streamer.sv
// Self-checking bench for fib_byte_streamer: constant vector table, randomized backpressure
// against an arithmetic Fibonacci model, and hand sequences for stall, clear and async reset.
`timescale 1ns/1ps
module tb_fib_byte_streamer;
  localparam int WIDTH = 32;
  localparam int BYTES = WIDTH / 8;
`ifdef FIB_BYTE_STREAMER_CHECKSUM_EN
  localparam int FRAME_LEN = BYTES + 1;
`else
  localparam int FRAME_LEN = BYTES;
`endif
  localparam longint unsigned MODV = 64'd1 << WIDTH;

  typedef struct {
    longint unsigned term;
    int              stall_at;
    int              stall_len;
    int              idx_after;
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  fib_byte_streamer_if bus();

  fib_byte_streamer #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  longint unsigned m_a;
  longint unsigned m_b;
  int              m_idx;
  bit              m_ovf;

  logic [7:0] got_data[$];
  logic       got_last[$];
  int         busy_low_edge;

  vec_t vecs[12];

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic model_reset();
    m_a   = 0;
    m_b   = 1;
    m_idx = 0;
    m_ovf = 0;
  endtask

  task automatic model_advance();
    longint unsigned s;
    s = m_a + m_b;
    if (s >= MODV) m_ovf = 1;
    m_a   = m_b;
    m_b   = s % MODV;
    m_idx = (m_idx + 1) % 256;
  endtask

  // Issues start from IDLE, collects one frame, then waits for busy to drop.
  task automatic run_frame(input int stall_at, input int stall_len, input bit rand_ready, input bit poke_start);
    int         edges;
    int         nb;
    int         stalled;
    logic [7:0] held_d;
    logic       held_l;
    bit         done;
    got_data.delete();
    got_last.delete();
    held_d = 8'h00;
    held_l = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check_output("start_latency_valid", 64'(bus.out_valid), 64'd1);
    edges   = 0;
    nb      = 0;
    stalled = 0;
    done    = 0;
    while (!done && edges < 300) begin
      if (nb == stall_at && stalled > 0) begin
        check_output("stall_data_stable", 64'(bus.out_data), 64'(held_d));
        check_output("stall_last_stable", 64'(bus.out_last), 64'(held_l));
      end
      if (nb == stall_at && stalled < stall_len) begin
        if (stalled == 0) begin
          held_d = bus.out_data;
          held_l = bus.out_last;
        end
        bus.out_ready = 1'b0;
        bus.start     = poke_start;
        stalled++;
      end else begin
        bus.start     = 1'b0;
        bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (bus.out_valid && bus.out_ready) begin
        got_data.push_back(bus.out_data);
        got_last.push_back(bus.out_last);
        nb++;
        if (bus.out_last || got_data.size() > FRAME_LEN) done = 1;
      end
      @(negedge clk);
      edges++;
    end
    bus.start     = 1'b0;
    bus.out_ready = 1'b0;
    if (!done) check_output("frame_timeout", 64'd0, 64'd1);
    while (bus.busy && edges < 400) begin
      @(negedge clk);
      edges++;
    end
    check_output("frame_end_idle", 64'(bus.busy), 64'd0);
    busy_low_edge = edges;
  endtask

  task automatic frame_check(input longint unsigned term, input string tag);
    logic [7:0] exp_b;
    logic [7:0] x;
    x = 8'h00;
    check_output({tag, "_len"}, 64'(got_data.size()), 64'(FRAME_LEN));
    for (int i = 0; i < FRAME_LEN; i++) begin
      if (i < BYTES) begin
        exp_b = 8'(term >> (8 * i));
        x     = x ^ exp_b;
      end else begin
        exp_b = x;
      end
      if (i < got_data.size()) begin
        check_output($sformatf("%s_byte%0d", tag, i), 64'(got_data[i]), 64'(exp_b));
        check_output($sformatf("%s_last%0d", tag, i), 64'(got_last[i]), 64'(i == FRAME_LEN - 1));
      end
    end
  endtask

  task automatic stream_model(input int stall_at, input int stall_len, input bit rand_ready);
    run_frame(stall_at, stall_len, rand_ready, 1'b0);
    frame_check(m_a, "model");
    model_advance();
    check_output("model_term_idx", 64'(bus.term_idx), 64'(m_idx));
    check_output("model_overflow", 64'(bus.overflow), 64'(m_ovf));
  endtask

  task automatic clear_mid_frame(input int accept_n);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start     = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < accept_n; i++) @(negedge clk);
    check_output("pre_clear_valid", 64'(bus.out_valid), 64'd1);
    bus.out_ready = 1'b0;
    bus.clear     = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    check_output("clear_valid", 64'(bus.out_valid), 64'd0);
    check_output("clear_busy", 64'(bus.busy), 64'd0);
    check_output("clear_overflow", 64'(bus.overflow), 64'd0);
    check_output("clear_term_idx", 64'(bus.term_idx), 64'd0);
    model_reset();
  endtask

  task automatic start_with_clear();
    bus.start = 1'b1;
    bus.clear = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.clear = 1'b0;
    check_output("start_clear_valid", 64'(bus.out_valid), 64'd0);
    check_output("start_clear_busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    check_output("start_clear_valid_late", 64'(bus.out_valid), 64'd0);
    model_reset();
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: got running expected finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.clear     = 1'b0;
    bus.out_ready = 1'b0;
    model_reset();

    vecs[0]  = '{64'd0,  -1, 0, 1};
    vecs[1]  = '{64'd1,  -1, 0, 2};
    vecs[2]  = '{64'd1,  -1, 0, 3};
    vecs[3]  = '{64'd2,   0, 2, 4};
    vecs[4]  = '{64'd3,  -1, 0, 5};
    vecs[5]  = '{64'd5,  -1, 0, 6};
    vecs[6]  = '{64'd8,  -1, 0, 7};
    vecs[7]  = '{64'd13,  2, 1, 8};
    vecs[8]  = '{64'd21, -1, 0, 9};
    vecs[9]  = '{64'd34, -1, 0, 10};
    vecs[10] = '{64'h37,  3, 4, 11};
    vecs[11] = '{64'd89, -1, 0, 12};

    repeat (2) @(negedge clk);
    check_output("rst_valid", 64'(bus.out_valid), 64'd0);
    check_output("rst_busy", 64'(bus.busy), 64'd0);
    check_output("rst_data", 64'(bus.out_data), 64'd0);
    check_output("rst_last", 64'(bus.out_last), 64'd0);
    check_output("rst_overflow", 64'(bus.overflow), 64'd0);
    check_output("rst_term_idx", 64'(bus.term_idx), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] table vectors F(0)..F(11)");
    for (int i = 0; i < 12; i++) begin
      run_frame(vecs[i].stall_at, vecs[i].stall_len, 1'b0, 1'b0);
      frame_check(vecs[i].term, "tbl");
      model_advance();
      check_output("tbl_term_idx", 64'(bus.term_idx), 64'(vecs[i].idx_after));
      check_output("tbl_overflow", 64'(bus.overflow), 64'd0);
      if (i == 0) check_output("tbl_busy_low_edge", 64'(busy_low_edge), 64'(FRAME_LEN + 1));
    end

    $display("[TB] random backpressure F(12)..F(46)");
    for (int n = 12; n <= 46; n++) begin
      stream_model(-1, 0, 1'b1);
      if (m_idx == 46) check_output("ovf_after_F45", 64'(bus.overflow), 64'd0);
      if (m_idx == 47) check_output("ovf_after_F46", 64'(bus.overflow), 64'd1);
    end

    $display("[TB] stalled F(47) with ignored starts, then F(48)");
    run_frame(1, 3, 1'b0, 1'b1);
    frame_check(64'hB11924E1, "f47");
    model_advance();
    check_output("f47_term_idx", 64'(bus.term_idx), 64'd48);
    @(negedge clk);
    check_output("no_queued_start_valid", 64'(bus.out_valid), 64'd0);
    check_output("no_queued_start_busy", 64'(bus.busy), 64'd0);
    run_frame(-1, 0, 1'b0, 1'b0);
    frame_check(64'h1E8D0A40, "f48");
    model_advance();
    check_output("f48_term_idx", 64'(bus.term_idx), 64'd49);
    check_output("f48_overflow", 64'(bus.overflow), 64'd1);

    $display("[TB] clear mid-frame");
    @(negedge clk);
    clear_mid_frame(2);
    start_with_clear();
    stream_model(-1, 0, 1'b1);
    for (int n = 1; n <= 4; n++) stream_model(-1, 0, 1'b1);
    clear_mid_frame(2);
    start_with_clear();
    run_frame(-1, 0, 1'b0, 1'b0);
    frame_check(64'd0, "after_clear");
    model_advance();
    for (int n = 1; n <= 6; n++) stream_model(-1, 0, 1'b1);

    $display("[TB] async reset mid-frame of F(7)");
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check_output("pre_rst_valid", 64'(bus.out_valid), 64'd1);
    check_output("pre_rst_data", 64'(bus.out_data), 64'h0D);
    #1 rst = 1'b1;
    #1;
    check_output("async_rst_valid", 64'(bus.out_valid), 64'd0);
    check_output("async_rst_busy", 64'(bus.busy), 64'd0);
    check_output("async_rst_data", 64'(bus.out_data), 64'd0);
    check_output("async_rst_last", 64'(bus.out_last), 64'd0);
    check_output("async_rst_term_idx", 64'(bus.term_idx), 64'd0);
    #1 rst = 1'b0;
    model_reset();
    @(negedge clk);
    stream_model(-1, 0, 1'b0);
    check_output("post_rst_term_idx", 64'(bus.term_idx), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
